// File: rtl/ofm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ofm_pkg
// Purpose  : Shared FSM encodings and TX beat field layout for the OFM TX path
// Revision : 1.0
// ============================================================================
package ofm_pkg;

    localparam int c_BEAT_W   = 73;
    localparam int c_LAST_BIT = 72;
    localparam int c_KEEP_HI  = 71;
    localparam int c_KEEP_LO  = 64;
    localparam int c_DATA_HI  = 63;
    localparam int c_DATA_LO  = 0;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_XFER = 3'd1;
    localparam logic [2:0] S_DONE = 3'd2;

    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;

endpackage
`default_nettype wire

// File: rtl/ofm_tx_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : ofm_tx_arb_if
// Purpose  : 64-bit AXI-Stream link from the TX arbiter to the 10GbE MAC
// Revision : 1.0
// ============================================================================
interface ofm_tx_arb_if;

    logic [63:0] tx_axis_mac_tdata;
    logic [7:0]  tx_axis_mac_tkeep;
    logic        tx_axis_mac_tvalid;
    logic        tx_axis_mac_tlast;
    logic        tx_axis_mac_tuser;
    logic        tx_axis_mac_tready;

    modport master (
        output tx_axis_mac_tdata,
        output tx_axis_mac_tkeep,
        output tx_axis_mac_tvalid,
        output tx_axis_mac_tlast,
        output tx_axis_mac_tuser,
        input  tx_axis_mac_tready
    );

    modport slave (
        input  tx_axis_mac_tdata,
        input  tx_axis_mac_tkeep,
        input  tx_axis_mac_tvalid,
        input  tx_axis_mac_tlast,
        input  tx_axis_mac_tuser,
        output tx_axis_mac_tready
    );

endinterface
`default_nettype wire

// File: rtl/ofm_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : ofm_rr_pick
// Purpose  : Combinational two-way round-robin picker
// Revision : 1.0
// ============================================================================
module ofm_rr_pick (
    input  wire logic [1:0] req,
    input  wire logic       last_served,
    output logic            pick,
    output logic            any
);

    always_comb begin
        any  = |req;
        // On a tie the channel that did not go last wins; otherwise the lone requester.
        if (req == 2'b11) begin
            pick = ~last_served;
        end else begin
            pick = req[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ofm_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : ofm_tx_arb
// Purpose  : Frame-level round-robin arbiter of two TX queues onto the MAC
// Revision : 1.0
// ============================================================================
module ofm_tx_arb
    import ofm_pkg::*;
#(
    parameter int C_CNT_W = 16
) (
    input  wire logic               tx_clk,
    input  wire logic               rst,
    input  wire logic [1:0]         ctrl_fifo_empty,
    output logic      [1:0]         ctrl_fifo_rden,
    input  wire logic [72:0]        data_fifo_rdata0,
    input  wire logic [72:0]        data_fifo_rdata1,
    input  wire logic [1:0]         data_fifo_empty,
    output logic      [1:0]         data_fifo_rden,
    ofm_tx_arb_if.master            m_axis,
    output logic      [C_CNT_W-1:0] frame_cnt0,
    output logic      [C_CNT_W-1:0] frame_cnt1,
    output logic      [3:0]         ofm_tx_arb_dbg
);

    logic [2:0]         r_state;
    logic               r_grant;
    logic               r_last_served;
    logic [C_CNT_W-1:0] r_frame_cnt0;
    logic [C_CNT_W-1:0] r_frame_cnt1;

    logic               w_pick;
    logic               w_any;
    logic [72:0]        w_head;
    logic               w_xfer;
    logic               w_tvalid;
    logic               w_accept;

    localparam logic [C_CNT_W-1:0] c_ONE = {{(C_CNT_W-1){1'b0}}, 1'b1};

    ofm_rr_pick u_rr_pick (
        .req         (~ctrl_fifo_empty),
        .last_served (r_last_served),
        .pick        (w_pick),
        .any         (w_any)
    );

    // Outputs depend only on state, grant and FIFO heads; tready gates pops, never tvalid.
    always_comb begin
        w_head   = r_grant ? data_fifo_rdata1 : data_fifo_rdata0;
        w_xfer   = (r_state == S_XFER);
        w_tvalid = w_xfer & ~data_fifo_empty[r_grant];
        w_accept = w_tvalid & m_axis.tx_axis_mac_tready;

        m_axis.tx_axis_mac_tvalid = w_tvalid;
        m_axis.tx_axis_mac_tlast  = w_tvalid & w_head[c_LAST_BIT];
        m_axis.tx_axis_mac_tdata  = w_xfer ? w_head[c_DATA_HI:c_DATA_LO] : 64'd0;
        m_axis.tx_axis_mac_tkeep  = w_xfer ? w_head[c_KEEP_HI:c_KEEP_LO] : 8'd0;
        m_axis.tx_axis_mac_tuser  = 1'b0;

        data_fifo_rden = 2'b00;
        ctrl_fifo_rden = 2'b00;
        if (w_accept) begin
            data_fifo_rden[r_grant] = 1'b1;
        end
        if (r_state == S_DONE) begin
            ctrl_fifo_rden[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_grant       <= 1'b0;
            r_last_served <= 1'b1;
            r_frame_cnt0  <= '0;
            r_frame_cnt1  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_accept && w_head[c_LAST_BIT]) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_last_served <= r_grant;
                    if (r_grant) begin
                        r_frame_cnt1 <= r_frame_cnt1 + c_ONE;
                    end else begin
                        r_frame_cnt0 <= r_frame_cnt0 + c_ONE;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign frame_cnt0     = r_frame_cnt0;
    assign frame_cnt1     = r_frame_cnt1;
    assign ofm_tx_arb_dbg = {r_grant, r_state};

endmodule
`default_nettype wire

// File: tb/tb_ofm_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofm_tx_arb
// Purpose  : Directed self-checking bench for ofm_tx_arb with queue-based FIFOs
// Revision : 1.0
// ============================================================================
module tb_ofm_tx_arb;
    import ofm_pkg::*;

    localparam int CW = 4;

    logic          tx_clk = 1'b0;
    logic          rst;
    logic [1:0]    ctrl_fifo_empty;
    logic [1:0]    ctrl_fifo_rden;
    logic [72:0]   data_fifo_rdata0;
    logic [72:0]   data_fifo_rdata1;
    logic [1:0]    data_fifo_empty;
    logic [1:0]    data_fifo_rden;
    logic [CW-1:0] frame_cnt0;
    logic [CW-1:0] frame_cnt1;
    logic [3:0]    ofm_tx_arb_dbg;

    ofm_tx_arb_if axis ();

    ofm_tx_arb #(.C_CNT_W(CW)) dut (
        .tx_clk           (tx_clk),
        .rst              (rst),
        .ctrl_fifo_empty  (ctrl_fifo_empty),
        .ctrl_fifo_rden   (ctrl_fifo_rden),
        .data_fifo_rdata0 (data_fifo_rdata0),
        .data_fifo_rdata1 (data_fifo_rdata1),
        .data_fifo_empty  (data_fifo_empty),
        .data_fifo_rden   (data_fifo_rden),
        .m_axis           (axis),
        .frame_cnt0       (frame_cnt0),
        .frame_cnt1       (frame_cnt1),
        .ofm_tx_arb_dbg   (ofm_tx_arb_dbg)
    );

    always #5 tx_clk = ~tx_clk;

    logic [72:0] dq0[$];
    logic [72:0] dq1[$];
    int          cq0, cq1;
    logic [1:0]  hold;
    logic [72:0] obs_q[$];
    int          pop_q[$];
    int          checks, errors;

    logic        s_tvalid, s_tlast, s_tuser;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic [1:0]  s_crden, s_drden;
    logic [3:0]  s_dbg;
    logic [CW-1:0] s_cnt0, s_cnt1;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        ctrl_fifo_empty  = {cq1 == 0, cq0 == 0};
        data_fifo_empty  = {hold[1] || dq1.size() == 0, hold[0] || dq0.size() == 0};
        data_fifo_rdata0 = (dq0.size() > 0) ? dq0[0] : 73'd0;
        data_fifo_rdata1 = (dq1.size() > 0) ? dq1[0] : 73'd0;
    endtask

    // Sample on the falling edge, then apply the FIFO pops the DUT requested.
    task automatic step();
        @(negedge tx_clk);
        s_tvalid = axis.tx_axis_mac_tvalid;
        s_tlast  = axis.tx_axis_mac_tlast;
        s_tuser  = axis.tx_axis_mac_tuser;
        s_tdata  = axis.tx_axis_mac_tdata;
        s_tkeep  = axis.tx_axis_mac_tkeep;
        s_crden  = ctrl_fifo_rden;
        s_drden  = data_fifo_rden;
        s_dbg    = ofm_tx_arb_dbg;
        s_cnt0   = frame_cnt0;
        s_cnt1   = frame_cnt1;
        if (s_tvalid && axis.tx_axis_mac_tready) obs_q.push_back({s_tlast, s_tkeep, s_tdata});
        if (s_crden[0]) pop_q.push_back(0);
        if (s_crden[1]) pop_q.push_back(1);
        @(posedge tx_clk);
        #1;
        if (s_drden[0] && dq0.size() > 0) dq0.delete(0);
        if (s_drden[1] && dq1.size() > 0) dq1.delete(0);
        if (s_crden[0] && cq0 > 0) cq0--;
        if (s_crden[1] && cq1 > 0) cq1--;
        drive();
    endtask

    function automatic logic [72:0] make_beat(input int tag, input int idx, input int n);
        beat_t b;
        b.last = (idx == n - 1);
        b.keep = b.last ? 8'h0F : 8'hFF;
        b.data = {32'(tag), 32'(idx)};
        return b;
    endfunction

    task automatic push_frame(input int ch, input int tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (ch == 1) dq1.push_back(make_beat(tag, i, n));
            else         dq0.push_back(make_beat(tag, i, n));
        end
        if (ch == 1) cq1++;
        else         cq0++;
    endtask

    task automatic expect_frame(input string tag, input int tagv, input int n);
        for (int i = 0; i < n; i++) begin
            if (obs_q.size() == 0) check_val({tag, "_missing"}, 128'd0, 128'd1);
            else                   check_val(tag, obs_q.pop_front(), make_beat(tagv, i, n));
        end
    endtask

    task automatic run_until(input string tag, input int npops, input int budget);
        int k;
        k = 0;
        while (pop_q.size() < npops && k < budget) begin
            step();
            k++;
        end
        check_val({tag, "_pops"}, pop_q.size(), npops);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dq0.delete();
        dq1.delete();
        cq0 = 0;
        cq1 = 0;
        hold = 2'b00;
        axis.tx_axis_mac_tready = 1'b1;
        drive();
        step();
        step();
        obs_q.delete();
        pop_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int pops;
        int exp_order[4];
        checks = 0;
        errors = 0;
        @(posedge tx_clk);
        #1;
        do_reset();
        step();

        // Reset state: everything zero.
        check_val("rst_tvalid", s_tvalid, 0);
        check_val("rst_tlast",  s_tlast, 0);
        check_val("rst_tuser",  s_tuser, 0);
        check_val("rst_tdata",  s_tdata, 0);
        check_val("rst_tkeep",  s_tkeep, 0);
        check_val("rst_rden",   {s_crden, s_drden}, 0);
        check_val("rst_cnt",    {s_cnt0, s_cnt1}, 0);
        check_val("rst_dbg",    s_dbg, 0);
        rst = 1'b0;

        // Channel 0 only, 3-beat frame.
        push_frame(0, 'hA1, 3);
        drive();
        step();
        check_val("t1_idle_tvalid", s_tvalid, 0);
        for (int b = 0; b < 3; b++) begin
            step();
            check_val("t1_tvalid", s_tvalid, 1);
            check_val("t1_tkeep",  s_tkeep, (b == 2) ? 8'h0F : 8'hFF);
            check_val("t1_tlast",  s_tlast, (b == 2));
            check_val("t1_drden",  s_drden, 2'b01);
            check_val("t1_crden",  s_crden, 2'b00);
        end
        step();
        check_val("t1_done_crden",  s_crden, 2'b01);
        check_val("t1_done_tvalid", s_tvalid, 0);
        check_val("t1_done_dbg",    s_dbg, {1'b0, S_DONE});
        step();
        check_val("t1_cnt0", s_cnt0, 1);
        check_val("t1_idle_dbg", s_dbg, {1'b0, S_IDLE});
        expect_frame("t1_beat", 'hA1, 3);

        // Both channels with two frames each, eligible from reset.
        do_reset();
        push_frame(0, 'h20, 2);
        push_frame(0, 'h21, 2);
        push_frame(1, 'h30, 2);
        push_frame(1, 'h31, 2);
        drive();
        step();
        rst = 1'b0;
        run_until("t2", 4, 200);
        exp_order = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++)
            check_val("t2_order", (i < pop_q.size()) ? pop_q[i] : -1, exp_order[i]);
        step();
        check_val("t2_cnt0", s_cnt0, 2);
        check_val("t2_cnt1", s_cnt1, 2);
        expect_frame("t2_f20", 'h20, 2);
        expect_frame("t2_f30", 'h30, 2);
        expect_frame("t2_f21", 'h21, 2);
        expect_frame("t2_f31", 'h31, 2);

        // tready toggling during a 4-beat frame.
        obs_q.delete();
        pop_q.delete();
        push_frame(0, 'h40, 4);
        drive();
        pops = 0;
        for (int k = 0; k < 40 && pop_q.size() < 1; k++) begin
            axis.tx_axis_mac_tready = (k % 2 == 0);
            step();
            if (!axis.tx_axis_mac_tready) check_val("t3_stall_no_pop", s_drden, 2'b00);
            if (s_drden[0]) pops++;
        end
        axis.tx_axis_mac_tready = 1'b1;
        check_val("t3_pop_count", pops, 4);
        check_val("t3_ctrl_pops", pop_q.size(), 1);
        expect_frame("t3_beat", 'h40, 4);

        // Granted data FIFO runs dry mid-frame while the other channel becomes eligible.
        obs_q.delete();
        pop_q.delete();
        push_frame(0, 'h50, 4);
        drive();
        for (int k = 0; k < 10 && obs_q.size() < 1; k++) step();
        hold[0] = 1'b1;
        push_frame(1, 'h60, 2);
        drive();
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("t4_stall", {s_tvalid, s_crden, s_drden, s_dbg}, {1'b0, 2'b00, 2'b00, 1'b0, S_XFER});
        end
        hold[0] = 1'b0;
        drive();
        run_until("t4", 2, 100);
        check_val("t4_first_pop",  (pop_q.size() > 0) ? pop_q[0] : -1, 0);
        check_val("t4_second_pop", (pop_q.size() > 1) ? pop_q[1] : -1, 1);
        expect_frame("t4_f50", 'h50, 4);
        expect_frame("t4_f60", 'h60, 2);

        // Reset during beat 2 abandons the frame.
        obs_q.delete();
        pop_q.delete();
        push_frame(0, 'h70, 3);
        drive();
        for (int k = 0; k < 10 && obs_q.size() < 1; k++) step();
        rst = 1'b1;
        step();
        step();
        check_val("t5_outputs", {s_tvalid, s_tlast, s_tkeep, s_tdata, s_crden, s_drden}, 0);
        check_val("t5_cnt", {s_cnt0, s_cnt1}, 0);
        check_val("t5_no_ctrl_pop", pop_q.size(), 0);
        do_reset();
        push_frame(0, 'h80, 1);
        push_frame(1, 'h90, 1);
        drive();
        step();
        rst = 1'b0;
        run_until("t5", 2, 50);
        check_val("t5_first_grant", (pop_q.size() > 0) ? pop_q[0] : -1, 0);
        expect_frame("t5_f80", 'h80, 1);

        // 17 single-beat frames on a 4-bit counter wrap to 1.
        do_reset();
        for (int i = 0; i < 17; i++) push_frame(0, 'hB0 + i, 1);
        drive();
        step();
        rst = 1'b0;
        run_until("t6", 17, 17 * 4 + 20);
        step();
        check_val("t6_cnt0_wrap", s_cnt0, 1);
        check_val("t6_cnt1", s_cnt1, 0);
        check_val("t6_beats", obs_q.size(), 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
